// File: rtl/goal_score_ctl.sv
// Goal detection, score keeping and score-marker overlay stage.
// Optional GOAL_FLASH_EN macro adds a flashing border in the scorer's colour during HOLD.
module goal_score_ctl #(
  parameter int          GOAL_X_LEFT  = 20,
  parameter int          GOAL_X_RIGHT = 1003,
  parameter int          GOAL_Y_TOP   = 284,
  parameter int          GOAL_Y_BOT   = 483,
  parameter int          WIN_SCORE    = 7,
  parameter int          HOLD_FRAMES  = 60,
  parameter int          MARK_Y       = 8,
  parameter int          MARK_X1      = 16,
  parameter int          MARK_X2      = 1007,
  parameter logic [11:0] COLOR_P1     = 12'hf00,
  parameter logic [11:0] COLOR_P2     = 12'h00f,
  parameter logic [11:0] COLOR_WIN    = 12'hff0
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] ball_xpos,
  input  logic [11:0] ball_ypos,
  input  logic        restart,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        goal,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        game_over,
  output logic        winner
);

  localparam logic [11:0] GXL    = 12'(GOAL_X_LEFT);
  localparam logic [11:0] GXR    = 12'(GOAL_X_RIGHT);
  localparam logic [11:0] GYT    = 12'(GOAL_Y_TOP);
  localparam logic [11:0] GYB    = 12'(GOAL_Y_BOT);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
  localparam logic [15:0] HOLD_N = 16'(HOLD_FRAMES);
  localparam logic [11:0] MY     = 12'(MARK_Y);
  localparam logic [11:0] MY_END = 12'(MARK_Y + 8);
  localparam logic [11:0] MX1    = 12'(MARK_X1);
  localparam logic [11:0] MX2    = 12'(MARK_X2);

  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    OVER
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  s1_nxt, s2_nxt;
  logic        vs_prev;
  logic        goal_nxt, win_nxt;
  logic        tick, y_in, left_hit, right_hit;
  logic        band, m1, m2;
  logic [11:0] off1, off2, c1, c2, pix;
`ifdef GOAL_FLASH_EN
  logic        side, side_nxt;
  logic        border;
`endif

  assign tick      = vsync_in & ~vs_prev;
  assign y_in      = (ball_ypos >= GYT) && (ball_ypos <= GYB);
  assign left_hit  = (ball_xpos <= GXL) && y_in;
  assign right_hit = (ball_xpos >= GXR) && y_in;
  assign game_over = (state == OVER);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    s1_nxt    = score_p1;
    s2_nxt    = score_p2;
    goal_nxt  = 1'b0;
    win_nxt   = winner;
`ifdef GOAL_FLASH_EN
    side_nxt  = side;
`endif
    if (restart) begin
      state_nxt = PLAY;
      cnt_nxt   = '0;
      s1_nxt    = '0;
      s2_nxt    = '0;
      win_nxt   = 1'b0;
    end else begin
      unique case (state)
        PLAY: begin
          if (tick && (left_hit || right_hit)) begin
            goal_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = HOLD;
`ifdef GOAL_FLASH_EN
            side_nxt  = left_hit;
`endif
            // left goal means player 2 scored
            if (left_hit) begin
              if (score_p2 < WIN) s2_nxt = score_p2 + 4'd1;
            end else begin
              if (score_p1 < WIN) s1_nxt = score_p1 + 4'd1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cnt_nxt = cnt + 16'd1;
            if (cnt_nxt == HOLD_N) begin
              if (score_p1 == WIN || score_p2 == WIN) begin
                state_nxt = OVER;
                win_nxt   = (score_p2 == WIN);
              end else begin
                state_nxt = PLAY;
              end
            end
          end
        end
        OVER: ;
        default: state_nxt = PLAY;
      endcase
    end
  end

  always_comb begin
    band = (vcount_in >= MY) && (vcount_in < MY_END);
    off1 = hcount_in - MX1;
    off2 = MX2 - 12'd1 - hcount_in;
    m1   = band && (hcount_in >= MX1) &&
           (off1 < {4'b0, score_p1, 4'b0}) && !off1[3];
    m2   = band && (hcount_in < MX2) &&
           (off2 < {4'b0, score_p2, 4'b0}) && !off2[3];
    c1   = (game_over && !winner) ? COLOR_WIN : COLOR_P1;
    c2   = (game_over && winner) ? COLOR_WIN : COLOR_P2;
    pix  = rgb_in;
    if (m2) pix = c2;
    if (m1) pix = c1;
`ifdef GOAL_FLASH_EN
    border = (state == HOLD) && cnt[3] &&
             ((hcount_in <= 12'd3) ||
              (hcount_in >= 12'd1020 && hcount_in <= 12'd1023) ||
              (vcount_in <= 12'd3) ||
              (vcount_in >= 12'd764 && vcount_in <= 12'd767));
    if (border) pix = side ? COLOR_P2 : COLOR_P1;
`endif
    if (hblnk_in || vblnk_in) pix = '0;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= PLAY;
      cnt      <= '0;
      vs_prev  <= 1'b0;
      score_p1 <= '0;
      score_p2 <= '0;
      goal     <= 1'b0;
      winner   <= 1'b0;
`ifdef GOAL_FLASH_EN
      side     <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      vs_prev  <= vsync_in;
      score_p1 <= s1_nxt;
      score_p2 <= s2_nxt;
      goal     <= goal_nxt;
      winner   <= win_nxt;
`ifdef GOAL_FLASH_EN
      side     <= side_nxt;
`endif
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= pix;
    end
  end

endmodule

// File: tb/tb_goal_score_ctl.sv
// Bench for goal_score_ctl: pixel vectors through a scoreboard,
// plus goal/hold/win/restart/reset sequences driven by frame ticks.
module tb_goal_score_ctl;

  localparam logic [11:0] P1 = 12'hf00;
  localparam logic [11:0] P2 = 12'h00f;
  localparam logic [11:0] CW = 12'hff0;
  localparam logic [11:0] BG = 12'h123;
`ifdef GOAL_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] hcount_in, vcount_in, rgb_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] ball_xpos, ball_ypos;
  logic        restart;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic        goal, game_over, winner;
  logic [3:0]  score_p1, score_p2;

  int total = 0;
  int bad = 0;
  int gcnt = 0;
  int g0;

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] c;
    logic [11:0] e;
    string       nm;
  } vec_t;

  vec_t        tbl[$];
  logic [37:0] sb[$];
  string       sn[$];

  goal_score_ctl dut (
    .clk_in(clk_in), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
    .restart(restart),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .goal(goal),
    .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk_in) begin
    #1;
    if (goal === 1'b1) gcnt++;
  end

  always @(posedge clk_in) begin
    logic [37:0] e;
    string n;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n = sn.pop_front();
      chk(n, {vcount_out, hcount_out, hblnk_out, vblnk_out, rgb_out}, e);
    end
  end

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic pix(input logic [11:0] h, input logic [11:0] v,
                     input logic hb, input logic vb,
                     input logic [11:0] c, input logic [11:0] e,
                     input string nm);
    hcount_in = h;
    vcount_in = v;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = c;
    sb.push_back({v, h, hb, vb, e});
    sn.push_back(nm);
    step();
  endtask

  task automatic tick();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic ball(input int x, input int y);
    ball_xpos = 12'(x);
    ball_ypos = 12'(y);
  endtask

  // one shot at (x,y); on a goal, sit out the whole hold with the puck centred
  task automatic shot(input int x, input int y, input int want, input string nm);
    int g;
    g = gcnt;
    ball(x, y);
    tick();
    chk(nm, 64'(gcnt - g), 64'(want));
    ball(512, 384);
    if (want != 0) repeat (60) tick();
  endtask

  function automatic logic [63:0] outs();
    return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
            vblnk_out, rgb_out, goal, score_p1, score_p2, game_over, winner};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    hcount_in = '0; vcount_in = '0; rgb_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    restart = 1'b0;
    ball(512, 384);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_state", outs(), 64'd0);
    pix(12'd500, 12'd300, 1'b0, 1'b0, 12'h5a3, 12'h5a3, "thru");

    g0 = gcnt;
    ball(10, 400);
    tick();
    chk("goal_once", 64'(gcnt - g0), 64'd1);
    chk("left_p2", 64'(score_p2), 64'd1);
    chk("left_p1", 64'(score_p1), 64'd0);
    repeat (60) tick();
    chk("hold_no_goal", 64'(gcnt - g0), 64'd1);
    chk("hold_p2", 64'(score_p2), 64'd1);
    shot(1010, 300, 1, "replay_goal");
    chk("right_p1", 64'(score_p1), 64'd1);
    shot(1010, 100, 0, "y_out_nogoal");
    shot(1003, 284, 1, "edge_rt_goal");
    shot(20, 483, 1, "edge_lb_goal");
    shot(21, 400, 0, "x21_nogoal");
    shot(10, 484, 0, "y484_nogoal");
    shot(1002, 300, 0, "x1002_nogoal");
    chk("p1_2", 64'(score_p1), 64'd2);
    chk("p2_2", 64'(score_p2), 64'd2);

    tbl.push_back('{12'd16, 12'd10, 1'b0, 1'b0, BG, P1, "m1_16"});
    tbl.push_back('{12'd23, 12'd10, 1'b0, 1'b0, BG, P1, "m1_23"});
    tbl.push_back('{12'd24, 12'd10, 1'b0, 1'b0, BG, BG, "m1_gap"});
    tbl.push_back('{12'd32, 12'd10, 1'b0, 1'b0, BG, P1, "m1_32"});
    tbl.push_back('{12'd39, 12'd10, 1'b0, 1'b0, BG, P1, "m1_39"});
    tbl.push_back('{12'd40, 12'd10, 1'b0, 1'b0, BG, BG, "m1_40"});
    tbl.push_back('{12'd48, 12'd10, 1'b0, 1'b0, BG, BG, "m1_48"});
    tbl.push_back('{12'd15, 12'd10, 1'b0, 1'b0, BG, BG, "m1_15"});
    tbl.push_back('{12'd16, 12'd7, 1'b0, 1'b0, BG, BG, "band_7"});
    tbl.push_back('{12'd16, 12'd8, 1'b0, 1'b0, BG, P1, "band_8"});
    tbl.push_back('{12'd16, 12'd15, 1'b0, 1'b0, BG, P1, "band_15"});
    tbl.push_back('{12'd16, 12'd16, 1'b0, 1'b0, BG, BG, "band_16"});
    tbl.push_back('{12'd16, 12'd10, 1'b1, 1'b0, BG, 12'h000, "hblnk"});
    tbl.push_back('{12'd500, 12'd300, 1'b0, 1'b1, BG, 12'h000, "vblnk"});
    tbl.push_back('{12'd1006, 12'd10, 1'b0, 1'b0, BG, P2, "m2_1006"});
    tbl.push_back('{12'd999, 12'd10, 1'b0, 1'b0, BG, P2, "m2_999"});
    tbl.push_back('{12'd998, 12'd10, 1'b0, 1'b0, BG, BG, "m2_gap"});
    tbl.push_back('{12'd990, 12'd10, 1'b0, 1'b0, BG, P2, "m2_990"});
    tbl.push_back('{12'd983, 12'd10, 1'b0, 1'b0, BG, P2, "m2_983"});
    tbl.push_back('{12'd975, 12'd10, 1'b0, 1'b0, BG, BG, "m2_975"});
    tbl.push_back('{12'd974, 12'd10, 1'b0, 1'b0, BG, BG, "m2_974"});
    tbl.push_back('{12'd1007, 12'd10, 1'b0, 1'b0, BG, BG, "m2_1007"});
    for (int i = 0; i < tbl.size(); i++)
      pix(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].c, tbl[i].e, tbl[i].nm);

    repeat (4) shot(1010, 300, 1, "p1_run");
    chk("p1_6", 64'(score_p1), 64'd6);
    ball(1010, 300);
    tick();
    chk("p1_7", 64'(score_p1), 64'd7);
    chk("hold7_not_over", 64'(game_over), 64'd0);
    ball(512, 384);
    repeat (59) tick();
    chk("hold59_not_over", 64'(game_over), 64'd0);
    tick();
    chk("p1_over", 64'(game_over), 64'd1);
    chk("p1_winner", 64'(winner), 64'd0);
    shot(1010, 300, 0, "over_nogoal");
    chk("over_p1_frozen", 64'(score_p1), 64'd7);
    pix(12'd16, 12'd10, 1'b0, 1'b0, BG, CW, "over_m1_win");
    pix(12'd1006, 12'd10, 1'b0, 1'b0, BG, P2, "over_m2");

    g0 = gcnt;
    ball(10, 400);
    restart = 1'b1;
    vsync_in = 1'b1;
    step();
    restart = 1'b0;
    vsync_in = 1'b0;
    step();
    chk("restart_scores", 64'({score_p1, score_p2}), 64'd0);
    chk("restart_over", 64'({game_over, winner}), 64'd0);
    chk("restart_nogoal", 64'(gcnt - g0), 64'd0);
    tick();
    chk("after_restart_goal", 64'(gcnt - g0), 64'd1);
    chk("after_restart_p2", 64'(score_p2), 64'd1);
    ball(512, 384);
    for (int k = 0; k < 16; k++) begin
      pix(12'd0, 12'd0, 1'b0, 1'b0, BG, (FLASH && k >= 8) ? P2 : BG, "border");
      tick();
    end
    repeat (44) tick();
    pix(12'd0, 12'd0, 1'b0, 1'b0, BG, BG, "border_play");

    repeat (6) shot(10, 400, 1, "p2_run");
    chk("p2_7", 64'(score_p2), 64'd7);
    chk("p2_over", 64'(game_over), 64'd1);
    chk("p2_winner", 64'(winner), 64'd1);
    pix(12'd1006, 12'd10, 1'b0, 1'b0, BG, CW, "over_m2_win");
    pix(12'd16, 12'd10, 1'b0, 1'b0, BG, BG, "over_m1_zero");

    hcount_in = 12'd100; vcount_in = 12'd200; rgb_in = 12'hfff;
    hsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
    step();
    chk("pre_rst_hsync", 64'(hsync_out), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", outs(), 64'd0);
    repeat (3) step();
    chk("rst_held", outs(), 64'd0);
    hsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rst = 1'b0;
    step();
    pix(12'd500, 12'd300, 1'b0, 1'b0, 12'h5a3, 12'h5a3, "thru_after_rst");
    chk("rst_scores", 64'({score_p1, score_p2, game_over}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
